mrd_rdx5_gather: RTL and testbench

Serial-to-parallel gatherer sitting directly upstream of the radix-5 DFT core in the mixed-radix DFT datapath. Accepts one complex sample per valid cycle, assembles consecutive groups of five into a parallel vector, and emits that vector with a one-cycle valid pulse. It also emits a per-frame group index for downstream twiddle/reorder stages. The radix-5 core is fully pipelined with no backpressure, so this block has none either.

---
 rtl/mrd_pkg.sv | 5 +
 rtl/mrd_rdx5_gather.sv | 85 ++++++++
 tb/tb_mrd_rdx5_gather.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/mrd_pkg.sv
// rtl/mrd_pkg.sv - shared constants and types for the mixed-radix DFT datapath
package mrd_pkg;
  localparam int RDX5 = 5;
  typedef logic [2:0] slot_idx_t;
endpackage

// File: rtl/mrd_rdx5_gather.sv
// rtl/mrd_rdx5_gather.sv - serial-to-parallel gather of five complex samples ahead of the radix-5 core
// Optional macro MRD_RDX5_GATHER_ERR_EN enables the partial-group discard pulse on err.
module mrd_rdx5_gather
  import mrd_pkg::*;
#(
  parameter int wDataInOut = 30,
  parameter int wGrp       = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_val,
  input  logic                         in_sop,
  input  logic signed [wDataInOut-1:0] din_real,
  input  logic signed [wDataInOut-1:0] din_imag,
  output logic                         out_val,
  output logic signed [wDataInOut-1:0] dout_real [0:RDX5-1],
  output logic signed [wDataInOut-1:0] dout_imag [0:RDX5-1],
  output logic        [wGrp-1:0]       out_grp,
  output logic                         err
);

  localparam slot_idx_t LAST_SLOT = slot_idx_t'(RDX5 - 1);

  // The fifth sample bypasses storage and goes straight into the output register.
  logic signed [wDataInOut-1:0] slot_re [0:RDX5-2];
  logic signed [wDataInOut-1:0] slot_im [0:RDX5-2];
  slot_idx_t                    cnt;
  logic        [wGrp-1:0]       grp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      grp     <= '0;
      out_val <= 1'b0;
      out_grp <= '0;
      for (int i = 0; i < RDX5 - 1; i++) begin
        slot_re[i] <= '0;
        slot_im[i] <= '0;
      end
      for (int i = 0; i < RDX5; i++) begin
        dout_real[i] <= '0;
        dout_imag[i] <= '0;
      end
    end else begin
      out_val <= 1'b0;
      if (in_val) begin
        if (in_sop) begin
          // Frame start restarts the group even if a partial group is pending.
          slot_re[0] <= din_real;
          slot_im[0] <= din_imag;
          cnt        <= slot_idx_t'(1);
          grp        <= '0;
        end else if (cnt == LAST_SLOT) begin
          for (int i = 0; i < RDX5 - 1; i++) begin
            dout_real[i] <= slot_re[i];
            dout_imag[i] <= slot_im[i];
          end
          dout_real[RDX5-1] <= din_real;
          dout_imag[RDX5-1] <= din_imag;
          out_val           <= 1'b1;
          out_grp           <= grp;
          grp               <= grp + 1'b1;
          cnt               <= '0;
        end else begin
          slot_re[cnt[1:0]] <= din_real;
          slot_im[cnt[1:0]] <= din_imag;
          cnt               <= cnt + slot_idx_t'(1);
        end
      end
    end
  end

`ifdef MRD_RDX5_GATHER_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= in_val && in_sop && (cnt != '0);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mrd_rdx5_gather.sv
// tb/tb_mrd_rdx5_gather.sv - randomized self-checking bench for mrd_rdx5_gather against a queue model
module tb_mrd_rdx5_gather;

  localparam int W     = 30;
  localparam int W_GRP = 2;
  localparam int RDX   = 5;
`ifdef MRD_RDX5_GATHER_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_val = 1'b0;
  logic                in_sop = 1'b0;
  logic signed [W-1:0] din_real = '0;
  logic signed [W-1:0] din_imag = '0;
  logic                out_val;
  logic signed [W-1:0] dout_real [0:RDX-1];
  logic signed [W-1:0] dout_imag [0:RDX-1];
  logic [W_GRP-1:0]    out_grp;
  logic                err;

  int tests = 0;
  int fails = 0;

  mrd_rdx5_gather #(.wDataInOut(W), .wGrp(W_GRP)) dut (
    .clk(clk), .rst_n(rst_n), .in_val(in_val), .in_sop(in_sop),
    .din_real(din_real), .din_imag(din_imag), .out_val(out_val),
    .dout_real(dout_real), .dout_imag(dout_imag), .out_grp(out_grp), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue collects the current group; five entries make a group.
  logic signed [W-1:0] q_re [$];
  logic signed [W-1:0] q_im [$];
  int                  m_grp = 0;
  logic signed [W-1:0] exp_re [0:RDX-1];
  logic signed [W-1:0] exp_im [0:RDX-1];
  logic                exp_val = 1'b0;
  logic                exp_err = 1'b0;
  int                  exp_grp = 0;

  initial begin
    for (int i = 0; i < RDX; i++) begin
      exp_re[i] = '0;
      exp_im[i] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q_re.delete(); q_im.delete();
        m_grp = 0; exp_val = 1'b0; exp_err = 1'b0; exp_grp = 0;
        for (int i = 0; i < RDX; i++) begin
          exp_re[i] = '0;
          exp_im[i] = '0;
        end
      end else begin
        exp_val = 1'b0;
        exp_err = 1'b0;
        if (in_val) begin
          if (in_sop) begin
            if (q_re.size() != 0) exp_err = ERR_EN;
            q_re.delete(); q_im.delete();
            m_grp = 0;
          end
          q_re.push_back(din_real);
          q_im.push_back(din_imag);
          if (q_re.size() == RDX) begin
            for (int i = 0; i < RDX; i++) begin
              exp_re[i] = q_re[i];
              exp_im[i] = q_im[i];
            end
            exp_val = 1'b1;
            exp_grp = m_grp;
            m_grp   = (m_grp + 1) % (1 << W_GRP);
            q_re.delete(); q_im.delete();
          end
        end
      end
    end
  end

  logic chk_en = 1'b0;
  logic log_en = 1'b0;
  int   pulses = 0;
  int   grp_log [$];
  logic prev_val = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_val", 64'(out_val), 64'(exp_val));
      chk("err", 64'(err), 64'(exp_err));
      chk("out_grp", 64'(out_grp), 64'(exp_grp[W_GRP-1:0]));
      for (int i = 0; i < RDX; i++) begin
        chk($sformatf("dout_real[%0d]", i), 64'(dout_real[i]), 64'(exp_re[i]));
        chk($sformatf("dout_imag[%0d]", i), 64'(dout_imag[i]), 64'(exp_im[i]));
      end
      if (prev_val && out_val) chk("out_val_back_to_back", 64'(1), 64'(0));
    end
    if (out_val) begin
      pulses++;
      if (log_en) grp_log.push_back(int'(out_grp));
    end
    prev_val = out_val;
  end

  task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im, input logic sop);
    @(negedge clk);
    in_val = 1'b1; in_sop = sop; din_real = re; din_imag = im;
    @(posedge clk);
    #1;
    in_val = 1'b0; in_sop = 1'b0;
    din_real = W'($urandom); din_imag = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    #1;
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_out_grp", 64'(out_grp), 64'(0));
    chk("rst_dout_real0", 64'(dout_real[0]), 64'(0));
    idle(3);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // First frame: 1..5 / -1..-5 back to back
    for (int i = 1; i <= RDX; i++) send(W'(i), -W'(i), i == 1);
    chk("t1_out_val", 64'(out_val), 64'(1));
    chk("t1_dout_real0", 64'(dout_real[0]), 64'(W'(1)));
    chk("t1_dout_real4", 64'(dout_real[4]), 64'(W'(5)));
    chk("t1_dout_imag4", 64'(dout_imag[4]), 64'(-W'(5)));
    chk("t1_out_grp", 64'(out_grp), 64'(0));
    idle(2);

    // Ten samples with random gaps in a fresh frame
    p0 = pulses;
    log_en = 1'b1; grp_log.delete();
    for (int i = 0; i < 10; i++) begin
      send(W'($urandom), W'($urandom), i == 0);
      idle($urandom_range(0, 3));
    end
    idle(2);
    log_en = 1'b0;
    chk("t2_pulses", 64'(pulses - p0), 64'(2));
    chk("t2_grp_count", 64'(grp_log.size()), 64'(2));
    if (grp_log.size() == 2) begin
      chk("t2_grp0", 64'(grp_log[0]), 64'(0));
      chk("t2_grp1", 64'(grp_log[1]), 64'(1));
    end

    // Restart mid-group: 3 samples then in_sop with value 100
    for (int i = 0; i < 3; i++) send(W'(7 + i), W'(9), 1'b0);
    send(W'(100), W'(200), 1'b1);
    chk("t3_err", 64'(err), 64'(ERR_EN));
    for (int i = 1; i < RDX; i++) send(W'(100 + i), W'(200 + i), 1'b0);
    chk("t3_out_val", 64'(out_val), 64'(1));
    chk("t3_dout_real0", 64'(dout_real[0]), 64'(100));
    chk("t3_dout_real4", 64'(dout_real[4]), 64'(104));
    chk("t3_out_grp", 64'(out_grp), 64'(0));
    idle(1);

    // Group index wraps with a 2-bit counter
    log_en = 1'b1; grp_log.delete();
    for (int i = 0; i < 5 * RDX; i++) begin
      send(W'($urandom), W'($urandom), i == 0);
      idle($urandom_range(0, 1));
    end
    idle(2);
    log_en = 1'b0;
    chk("t4_grp_count", 64'(grp_log.size()), 64'(5));
    if (grp_log.size() == 5) begin
      chk("t4_grp_seq2", 64'(grp_log[2]), 64'(2));
      chk("t4_grp_seq3", 64'(grp_log[3]), 64'(3));
      chk("t4_grp_seq4", 64'(grp_log[4]), 64'(0));
    end

    // Asynchronous reset with two samples pending
    send(W'(55), W'(66), 1'b0);
    send(W'(56), W'(67), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_val", 64'(out_val), 64'(0));
    chk("t5_rst_out_grp", 64'(out_grp), 64'(0));
    chk("t5_rst_dout_real0", 64'(dout_real[0]), 64'(0));
    chk("t5_rst_dout_imag4", 64'(dout_imag[4]), 64'(0));
    chk("t5_rst_err", 64'(err), 64'(0));
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < RDX; i++) send(W'(300 + i), W'(400 + i), 1'b0);
    chk("t5_out_val", 64'(out_val), 64'(1));
    chk("t5_dout_real0", 64'(dout_real[0]), 64'(300));
    chk("t5_dout_imag4", 64'(dout_imag[4]), 64'(404));
    idle(1);

    // Extreme values pass bit-exact
    for (int i = 0; i < RDX; i++) send((i % 2) ? SMAX : SMIN, (i % 2) ? SMIN : SMAX, i == 0);
    chk("t6_dout_real0", 64'(dout_real[0]), 64'(SMIN));
    chk("t6_dout_real1", 64'(dout_real[1]), 64'(SMAX));
    chk("t6_dout_imag0", 64'(dout_imag[0]), 64'(SMAX));
    chk("t6_dout_imag1", 64'(dout_imag[1]), 64'(SMIN));
    idle(1);

    // Random traffic with occasional frame starts
    for (int i = 0; i < 400; i++) begin
      send(W'($urandom), W'($urandom), ($urandom_range(0, 15) == 0));
      idle($urandom_range(0, 2));
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
